// File: rtl/alu_pkg.sv
// Shared definitions for the 3-bit ALU and its operand loader.
// Holds the operand width and the loader FSM state encodings.
package alu_pkg;

  localparam int unsigned W = 3;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_LOAD_OP = 2'd2,
    ST_READY   = 2'd3
  } load_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchroniser and debouncer for one bouncy active-high push button.
// Produces a registered one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // The counter only runs while the synchronised level disagrees with the
  // accepted level; any agreement (a bounce back) restarts the full count.
  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
        cnt_d    = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    pulse_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Turns slide switches and enter/clear buttons into latched ALU operands
// A, B and an op code, entered one after another.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw,
  input  logic         btn_enter,
  input  logic         btn_clear,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] ctrl,
  output logic         operands_valid,
  output logic [1:0]   step
);

  logic         enter_p;
  logic         clear_p;

  logic [W-1:0] sw_s1_q, sw_s1_d;
  logic [W-1:0] sw_s2_q, sw_s2_d;
  load_state_e  state_q, state_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] ctrl_q, ctrl_d;
  logic         valid_q, valid_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_enter),
    .pulse  (enter_p)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(btn_clear),
    .pulse  (clear_p)
  );

  // Clear takes priority over a simultaneous enter; READY + enter restarts
  // entry without touching the operands, which are overwritten later.
  always_comb begin
    sw_s1_d = sw;
    sw_s2_d = sw_s1_q;
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    if (clear_p) begin
      state_d = ST_LOAD_A;
      a_d     = {W{1'b0}};
      b_d     = {W{1'b0}};
      ctrl_d  = {W{1'b0}};
    end else if (enter_p) begin
      case (state_q)
        ST_LOAD_A: begin
          a_d     = sw_s2_q;
          state_d = ST_LOAD_B;
        end
        ST_LOAD_B: begin
          b_d     = sw_s2_q;
          state_d = ST_LOAD_OP;
        end
        ST_LOAD_OP: begin
          ctrl_d  = sw_s2_q;
          state_d = ST_READY;
        end
        ST_READY: begin
          state_d = ST_LOAD_A;
        end
        default: begin
          state_d = ST_LOAD_A;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    valid_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1_q <= {W{1'b0}};
      sw_s2_q <= {W{1'b0}};
      state_q <= ST_LOAD_A;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      ctrl_q  <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign a              = a_q;
  assign b              = b_q;
  assign ctrl           = ctrl_q;
  assign operands_valid = valid_q;
  assign step           = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed self-checking bench for alu_operand_loader with a short debounce.
module tb_alu_operand_loader;

  localparam int unsigned DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = 3'd0;
  logic       btn_enter = 1'b0;
  logic       btn_clear = 1'b0;
  logic [2:0] a, b, ctrl;
  logic       operands_valid;
  logic [1:0] step;

  int n_total = 0;
  int n_bad   = 0;
  int enter_cnt = 0;
  int clear_cnt = 0;

  alu_operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sw            (sw),
    .btn_enter     (btn_enter),
    .btn_clear     (btn_clear),
    .a             (a),
    .b             (b),
    .ctrl          (ctrl),
    .operands_valid(operands_valid),
    .step          (step)
  );

  always #5 clk = ~clk;

  // Counts debounced pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (dut.enter_p) enter_cnt = enter_cnt + 1;
    if (dut.clear_p) clear_cnt = clear_cnt + 1;
  end

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_total = n_total + 1;
    if (obs != exp_v) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the chosen buttons with sw set, hold, release and let it settle.
  task automatic press(input logic en, input logic cl, input logic [2:0] s, input int hold);
    sw        = s;
    btn_enter = en;
    btn_clear = cl;
    cycles(hold);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    cycles(12);
  endtask

  initial begin
    // Reset with switches at 7 and both buttons pressed.
    sw = 3'd7; btn_enter = 1'b1; btn_clear = 1'b1; rst_n = 1'b0;
    cycles(3);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_step", step, 0);
    chk("rst_valid", operands_valid, 0);
    enter_cnt = 0; clear_cnt = 0;
    rst_n = 1'b1;
    cycles(20);
    chk("rst_enter_pulses", enter_cnt, 1);
    chk("rst_clear_pulses", clear_cnt, 1);
    chk("rst_clear_wins_step", step, 0);
    chk("rst_clear_wins_a", a, 0);
    btn_enter = 1'b0; btn_clear = 1'b0;
    cycles(12);

    // Full entry; first capture lands exactly DB+3 edges after the press.
    sw = 3'd5; btn_enter = 1'b1;
    cycles(DB + 3);
    chk("lat_step_before", step, 0);
    chk("lat_a_before", a, 0);
    cycles(1);
    chk("lat_step_after", step, 1);
    chk("lat_a_after", a, 5);
    cycles(3);
    btn_enter = 1'b0;
    cycles(12);
    press(1'b1, 1'b0, 3'd3, 10);
    chk("entry_step_b", step, 2);
    chk("entry_valid_b", operands_valid, 0);
    press(1'b1, 1'b0, 3'd1, 10);
    chk("entry_a", a, 5);
    chk("entry_b", b, 3);
    chk("entry_ctrl", ctrl, 1);
    chk("entry_step", step, 3);
    chk("entry_valid", operands_valid, 1);

    // READY + enter returns to LOAD_A without capturing.
    press(1'b1, 1'b0, 3'd6, 10);
    chk("reent_step", step, 0);
    chk("reent_valid", operands_valid, 0);
    chk("reent_a", a, 5);
    chk("reent_b", b, 3);
    chk("reent_ctrl", ctrl, 1);
    press(1'b1, 1'b0, 3'd4, 10);
    chk("reent_new_a", a, 4);
    chk("reent_new_step", step, 1);

    // Bouncing enter never settles long enough to be accepted.
    enter_cnt = 0;
    sw = 3'd7;
    for (int i = 0; i < 10; i++) begin
      btn_enter = ~btn_enter;
      cycles(2);
    end
    btn_enter = 1'b0;
    cycles(12);
    chk("bounce_pulses", enter_cnt, 0);
    chk("bounce_step", step, 1);
    chk("bounce_b", b, 3);

    // Clear from mid-entry, then clear mid-entry again after new operands.
    press(1'b0, 1'b1, 3'd0, 10);
    chk("clr0_step", step, 0);
    chk("clr0_a", a, 0);
    chk("clr0_b", b, 0);
    chk("clr0_ctrl", ctrl, 0);
    press(1'b1, 1'b0, 3'd6, 10);
    press(1'b1, 1'b0, 3'd2, 10);
    chk("clr_pre_a", a, 6);
    chk("clr_pre_b", b, 2);
    chk("clr_pre_step", step, 2);
    press(1'b0, 1'b1, 3'd5, 10);
    chk("clr_a", a, 0);
    chk("clr_b", b, 0);
    chk("clr_ctrl", ctrl, 0);
    chk("clr_step", step, 0);
    press(1'b1, 1'b1, 3'd5, 10);
    chk("both_step", step, 0);
    chk("both_a", a, 0);

    // Long hold in LOAD_OP with op code 7 gives a single capture.
    press(1'b1, 1'b0, 3'd1, 10);
    press(1'b1, 1'b0, 3'd2, 10);
    chk("hold_pre_step", step, 2);
    enter_cnt = 0;
    press(1'b1, 1'b0, 3'd7, 50);
    chk("hold_pulses", enter_cnt, 1);
    chk("hold_ctrl", ctrl, 7);
    chk("hold_step", step, 3);
    chk("hold_valid", operands_valid, 1);
    chk("hold_a", a, 1);
    chk("hold_b", b, 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Input stage that sits directly upstream of the 3-bit ALU top. It turns three slide switches and two push buttons into latched operands A, B and a 3-bit operation code, entered one at a time. Both buttons are synchronised and debounced. The outputs drive the ALU's `A`, `B` and `ctrl` inputs, and `operands_valid` marks when all three have been entered.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz). Minimum 1.

Ports:
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: one clock; reset is synchronous and active-low.
- `sw` in 3: raw slide switches, asynchronous to `clk`.
- `btn_enter` in 1: raw, bouncy, active-high "enter" button.
- `btn_clear` in 1: raw, bouncy, active-high "clear" button.
- `a` out 3: latched operand A, to ALU `A`.
- `b` out 3: latched operand B, to ALU `B`.
- `ctrl` out 3: latched op code, to ALU `ctrl`.
- `operands_valid` out 1: high only in state READY.
- `step` out 2: current state encoding, for status LEDs.

## Operation
Input conditioning:
- `sw`, `btn_enter` and `btn_clear` each pass through a 2-flop synchroniser.
- Each synchronised button feeds one debouncer holding a stable level (reset 0) and a counter.
- The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
- When the synchronised level differs from the stable level, the counter increments. When it matches, the counter clears to 0.
- When the counter reaches `DEBOUNCE_CYCLES`, the stable level toggles and the counter clears.
- A stable 0→1 transition produces a registered one-cycle pulse (`enter_p` / `clear_p`). Releasing the button produces no pulse.
- A held button produces exactly one pulse.

FSM states and `step` encoding: LOAD_A=0, LOAD_B=1, LOAD_OP=2, READY=3. Reset state is LOAD_A.
- LOAD_A + `enter_p`: `a` ← synchronised `sw`; go to LOAD_B.
- LOAD_B + `enter_p`: `b` ← synchronised `sw`; go to LOAD_OP.
- LOAD_OP + `enter_p`: `ctrl` ← synchronised `sw`; go to READY.
- READY + `enter_p`: go to LOAD_A. No capture; `a`, `b`, `ctrl` hold their old values until overwritten.
- Any state + `clear_p`: go to LOAD_A and zero `a`, `b`, `ctrl`.
- `clear_p` and `enter_p` in the same cycle: clear wins and enter is discarded.
- Op codes 5–7 are captured unchanged; the ALU maps them to 0.
- `operands_valid` = (state == READY), registered.

## Timing
- Reset values: `a`=0, `b`=0, `ctrl`=0, `operands_valid`=0, `step`=0. All debouncer counters, stable levels and synchroniser flops are 0.
- A reset assertion mid-debounce or mid-entry discards all progress on the next clock edge.
- Capture latency, with a raw button rising before edge 0 and held clean:
  - pulse is high in the cycle after edge DEBOUNCE_CYCLES+2;
  - captured register and new `step` are visible after edge DEBOUNCE_CYCLES+3.
- `sw` must be stable for 2 cycles before that capture edge; the synchronised value is used.
- Bounce handling:
  - a bounce shorter than `DEBOUNCE_CYCLES` cycles resets the counter and produces no pulse;
  - each bounce restarts the full count.
- A release followed by a new press requires a full debounce in each direction: at least 2×`DEBOUNCE_CYCLES` cycles between pulses.
- Outputs are registered and change only on `clk` edges, so the downstream combinational ALU sees glitch-free operands.

## Structure
- Shared package `alu_pkg` holds the FSM state encodings `ST_LOAD_A`…`ST_READY` and the operand width constant `W=3`. The ALU top and this block use the same `W`.
- Sub-module `btn_debounce`, parameterised by `DEBOUNCE_CYCLES`:
  - contains the synchroniser, counter, stable level and rising-edge pulse;
  - instantiated twice (enter, clear).
- The `sw` synchroniser, FSM and operand registers stay in `alu_operand_loader`.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`.
- Reset: hold `rst_n`=0 for 3 cycles with `sw`=7 and both buttons high → `a`=`b`=`ctrl`=0, `step`=0, `operands_valid`=0. After release with buttons still high → exactly one enter pulse after debounce. Clear also pulses; clear wins, so the state stays LOAD_A with zeros.
- Full entry: clean enter presses with `sw`=5, then 3, then 1 → `a`=5, `b`=3, `ctrl`=1, `step`=3, `operands_valid`=1. The first capture is visible 7 edges after the press.
- Bounce: enter toggles every 2 cycles for 20 cycles, then drops low → no capture, `step` unchanged, counter never reaches 4.
- Clear mid-entry: after `a`=6 and `b`=2 are captured, press clear → `a`=`b`=`ctrl`=0, `step`=0. Press clear and enter in the same cycle → clear wins, no capture.
- READY re-entry: from READY with `a`=5, `b`=3, `ctrl`=1, press enter → `step`=0, `operands_valid`=0, `a`/`b`/`ctrl` unchanged. The next enter with `sw`=4 gives `a`=4.
- Held button and op code 7: hold enter for 50 cycles in LOAD_OP with `sw`=7 → exactly one capture, `ctrl`=7, state READY and no further advance.
